// File: rtl/cdc_handshake_rx.sv
// Receive-side endpoint of a 4-phase req/ack CDC handshake, clk_dest domain only.
// Captures each word into a one-entry holding register and presents it on valid/ready.
module cdc_handshake_rx #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk_dest,
    input  logic                  rst_n,
    input  logic                  req_sync,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  ack,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [CNT_WIDTH-1:0]  xfer_cnt,
    output logic                  err_withdraw,
    input  logic                  clr_err
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_ACK  = 1'b1
    } state_t;

    state_t                  r_state;
    state_t                  w_next_state;
    logic                    r_ack;
    logic                    r_m_valid;
    logic [DATA_WIDTH-1:0]   r_m_data;
    logic [CNT_WIDTH-1:0]    r_xfer_cnt;
    logic                    r_err;
    logic                    r_req_pend;
    logic                    w_space;
    logic                    w_pop;
    logic                    w_capture;
    logic                    w_withdraw;
    logic                    w_pend_next;

    // State register
    always_ff @(posedge clk_dest or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: leave ACK only once the source has dropped its request
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_capture) begin
                    w_next_state = ST_ACK;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_ACK: begin
                if (!req_sync) begin
                    w_next_state = ST_IDLE;
                end else begin
                    w_next_state = ST_ACK;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Per-state decode of capture, withdraw detection and pending-request tracking
    always_comb begin
        w_space     = !r_m_valid | m_ready;
        w_pop       = r_m_valid & m_ready;
        w_capture   = 1'b0;
        w_withdraw  = 1'b0;
        w_pend_next = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_capture   = req_sync & w_space;
                w_withdraw  = r_req_pend & !req_sync;
                w_pend_next = req_sync & !w_space;
            end
            ST_ACK: begin
                w_capture   = 1'b0;
                w_withdraw  = 1'b0;
                w_pend_next = 1'b0;
            end
            default: begin
                w_capture   = 1'b0;
                w_withdraw  = 1'b0;
                w_pend_next = 1'b0;
            end
        endcase
    end

    // Acknowledge mirrors the registered state so it never depends combinationally on inputs
    always_ff @(posedge clk_dest or negedge rst_n) begin
        if (!rst_n) begin
            r_ack <= 1'b0;
        end else begin
            r_ack <= (w_next_state == ST_ACK);
        end
    end

    // Holding register: capture wins over a same-cycle pop
    always_ff @(posedge clk_dest or negedge rst_n) begin
        if (!rst_n) begin
            r_m_valid <= 1'b0;
            r_m_data  <= {DATA_WIDTH{1'b0}};
        end else if (w_capture) begin
            r_m_valid <= 1'b1;
            r_m_data  <= in_data;
        end else if (w_pop) begin
            r_m_valid <= 1'b0;
            r_m_data  <= r_m_data;
        end else begin
            r_m_valid <= r_m_valid;
            r_m_data  <= r_m_data;
        end
    end

    // Transfer counter, wraps silently
    always_ff @(posedge clk_dest or negedge rst_n) begin
        if (!rst_n) begin
            r_xfer_cnt <= {CNT_WIDTH{1'b0}};
        end else if (w_capture) begin
            r_xfer_cnt <= r_xfer_cnt + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end else begin
            r_xfer_cnt <= r_xfer_cnt;
        end
    end

    // Sticky withdraw flag; a new violation beats a simultaneous clear
    always_ff @(posedge clk_dest or negedge rst_n) begin
        if (!rst_n) begin
            r_req_pend <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_req_pend <= w_pend_next;
            if (w_withdraw) begin
                r_err <= 1'b1;
            end else if (clr_err) begin
                r_err <= 1'b0;
            end else begin
                r_err <= r_err;
            end
        end
    end

    assign ack          = r_ack;
    assign m_valid      = r_m_valid;
    assign m_data       = r_m_data;
    assign xfer_cnt     = r_xfer_cnt;
    assign err_withdraw = r_err;

endmodule

// File: doc/cdc_handshake_rx.md
# cdc_handshake_rx

Single-clock receive-side endpoint of the 4-phase req/ack CDC handshake, living entirely in the destination clock domain. It consumes the already-synchronized request and the quasi-static data bus held by the source, and captures each word into a one-entry holding register. It presents the word downstream on a valid/ready interface and drives the acknowledge back toward the synchronizer, stalling the acknowledge while downstream is full. It also counts completed transfers and flags protocol violations.

## Interface
- DATA_WIDTH, 8, width of the transferred word
- CNT_WIDTH, 16, width of the transfer counter
- clk_dest  input  1  destination-domain clock; all logic on its rising edge
- rst_n  input  1  asynchronous, active-low reset
- req_sync  input  1  request from the CDC synchronizer, already synchronized to clk_dest
- in_data  input  DATA_WIDTH  source data bus; held stable by the source while its request is high
- ack  output  1  registered acknowledge back to the synchronizer
- m_data  output  DATA_WIDTH  captured word
- m_valid  output  1  m_data holds an unconsumed word
- m_ready  input  1  downstream accepts m_data on the cycle when m_valid & m_ready
- xfer_cnt  output  CNT_WIDTH  number of words captured since reset; wraps modulo 2^CNT_WIDTH
- err_withdraw  output  1  sticky flag: request dropped before it was acknowledged
- clr_err  input  1  synchronous clear of err_withdraw

## Operation
- Reset (rst_n low, asynchronous, effective immediately): state=IDLE, ack=0, m_valid=0, m_data=0, xfer_cnt=0, err_withdraw=0.
- Space condition: space = !m_valid | m_ready, i.e. the holding register is empty or is being popped this cycle.
- FSM, two states:
  - IDLE (ack=0). If req_sync & space: m_data<=in_data, m_valid<=1, ack<=1, xfer_cnt<=xfer_cnt+1, go to ACK. If req_sync & !space: stay, ack stays 0 (backpressure). Otherwise stay.
  - ACK (ack=1). Wait for req_sync=0, then ack<=0 and go to IDLE. While in ACK, in_data is ignored and no capture occurs.
- Holding register: a pop (m_valid & m_ready) clears m_valid unless a capture occurs in the same cycle. On pop plus capture in the same cycle, m_valid stays 1 and m_data takes the new word.
- m_data is held stable while m_valid=1 and no pop occurs.
- err_withdraw: set in the cycle after the block observes, in IDLE, req_sync high on one edge and low on the next edge with no capture in between. This means the source withdrew an unacknowledged request. err_withdraw stays set until clr_err=1; if set and clear coincide, set wins.
- xfer_cnt increments only on capture and wraps from all-ones to 0 with no flag.
- Reset mid-transfer: ack drops immediately and any held word is discarded. After reset the block starts in IDLE; if req_sync is still high, it captures on the first edge after reset release, provided space.

## Timing
- Capture latency: req_sync first seen high at edge N with space -> ack, m_valid and m_data updated after edge N (1 cycle, registered).
- Release latency: req_sync first seen low at edge M while in ACK -> ack=0 after edge M.
- Earliest next capture is edge M+1, if req_sync is already high again.
- Throughput bound: 1 word per 2 clk_dest cycles, plus synchronizer round trips.
- Backpressure: while m_valid=1 and m_ready=0, ack stays low and req_sync is left pending. Capture happens on the first edge where m_ready=1.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Single transfer: req_sync rises at edge 5 with in_data=0xA5, m_ready=1 -> after edge 5 ack=1, m_valid=1, m_data=0xA5, xfer_cnt=1. req_sync falls at edge 9 -> after edge 9 ack=0.
- Backpressure: m_valid=1, m_ready=0, req_sync high with in_data=0x3C -> ack stays 0, m_data keeps the old word. m_ready=1 at edge K -> after edge K m_data=0x3C, ack=1, m_valid=1 (pop plus capture).
- Back-to-back: 4 handshakes with words 0x01..0x04, m_ready tied 1, req_sync toggling as fast as protocol allows -> 4 words delivered in order, captures ≥2 cycles apart, xfer_cnt=4, err_withdraw=0.
- Withdraw error: m_valid=1, m_ready=0, req_sync high for 3 cycles then low -> no capture, ack stays 0, err_withdraw=1 after the falling edge is seen. clr_err pulse -> err_withdraw=0.
- Counter wrap: CNT_WIDTH=4, 17 transfers -> xfer_cnt=1.
- Async reset mid-ACK: assert rst_n low between edges while ack=1, m_valid=1 -> ack=0 and m_valid=0 immediately. Release with req_sync high and m_ready=1 -> capture on the first edge after release.
